// File: rtl/wave_capture_pkg.sv
// Shared constants for the wave_capture frame recorder:
// FSM state encodings and trigger edge selects.
package wave_capture_pkg;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_PRE  = 3'd1;
    localparam logic [2:0] ST_WAIT = 3'd2;
    localparam logic [2:0] ST_POST = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    localparam logic EDGE_RISE = 1'b0;
    localparam logic EDGE_FALL = 1'b1;

    function automatic logic is_busy(input logic [2:0] st);
        return (st == ST_PRE) || (st == ST_WAIT) || (st == ST_POST);
    endfunction

endpackage

// File: rtl/wave_capture_trig_detect.sv
// Level-crossing detector: keeps the previous decimated sample
// and flags a rising or falling crossing of the threshold.
module trig_detect
    import wave_capture_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              sample_en,
    input  logic [DATA_W-1:0] cur,
    input  logic [DATA_W-1:0] level,
    input  logic              edge_sel,
    output logic              hit
);

    logic [DATA_W-1:0] prev_q;
    logic              prev_valid_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q       <= '0;
            prev_valid_q <= 1'b0;
        end else if (clr) begin
            prev_valid_q <= 1'b0;
        end else if (sample_en) begin
            prev_q       <= cur;
            prev_valid_q <= 1'b1;
        end
    end

    // A stale prev from an earlier frame must never fire the first sample
    always_comb begin
        hit = 1'b0;
        if (prev_valid_q) begin
            if (edge_sel == EDGE_FALL)
                hit = (prev_q > level) && (cur <= level);
            else
                hit = (prev_q < level) && (cur >= level);
        end
    end

endmodule

// File: rtl/wave_capture.sv
// Pre/post-trigger waveform recorder writing a circular RAM frame.
// Optional timeout trigger: define AUTO_TRIG_EN.
module wave_capture
    import wave_capture_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 9,
    parameter int AUTO_TMO = 1023
) (
    input  logic              ad_clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] ad_data,
    input  logic              deci_valid,
    input  logic [DATA_W-1:0] trig_level,
    input  logic              trig_edge,
    input  logic [ADDR_W-1:0] pre_depth,
    input  logic              arm,
    input  logic              rd_ack,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic [ADDR_W-1:0] trig_addr,
    output logic              trig_forced,
    output logic              busy,
    output logic              frame_done
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] PRE_MAX  = ADDR_W'(DEPTH - 2);
    localparam logic [ADDR_W-1:0] POST_TOT = ADDR_W'(DEPTH - 1);

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [ADDR_W-1:0] pre_q, pre_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic [ADDR_W-1:0] trig_addr_q, trig_addr_d;
    logic              forced_q, forced_d;

    logic              busy_s;
    logic              start;
    logic              sample;
    logic              hit;
    logic              tmo_hit;
    logic [ADDR_W-1:0] pre_clamp;
    logic [ADDR_W-1:0] post_len;

    assign busy_s    = is_busy(state_q);
    assign sample    = deci_valid && busy_s;
    assign start     = arm && ((state_q == ST_IDLE) ||
                               ((state_q == ST_DONE) && rd_ack));
    assign pre_clamp = (pre_depth > PRE_MAX) ? PRE_MAX : pre_depth;
    assign post_len  = POST_TOT - pre_q;

    trig_detect #(
        .DATA_W(DATA_W)
    ) u_trig (
        .clk      (ad_clk),
        .rst      (rst),
        .clr      (start),
        .sample_en(sample),
        .cur      (ad_data),
        .level    (trig_level),
        .edge_sel (trig_edge),
        .hit      (hit)
    );

`ifdef AUTO_TRIG_EN
    localparam int TMO_W = $clog2(AUTO_TMO + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(AUTO_TMO - 1);

    logic [TMO_W-1:0] tmo_q, tmo_d;

    always_comb begin
        tmo_d = tmo_q;
        if (start)
            tmo_d = '0;
        else if (sample && (state_q == ST_WAIT))
            tmo_d = tmo_q + 1'b1;
    end

    always_ff @(posedge ad_clk) begin
        if (rst)
            tmo_q <= '0;
        else
            tmo_q <= tmo_d;
    end

    assign tmo_hit = sample && (state_q == ST_WAIT) && (tmo_q == TMO_LAST);
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        pre_d       = pre_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        trig_addr_d = trig_addr_q;
        forced_d    = forced_q;

        if (start) begin
            state_d  = (pre_clamp == '0) ? ST_WAIT : ST_PRE;
            ptr_d    = '0;
            cnt_d    = '0;
            pre_d    = pre_clamp;
            forced_d = 1'b0;
        end else if (sample) begin
            wr_en_d   = 1'b1;
            wr_addr_d = ptr_q;
            wr_data_d = ad_data;
            ptr_d     = ptr_q + 1'b1;
            unique case (state_q)
                ST_PRE: begin
                    if (cnt_q == pre_q - 1'b1) begin
                        state_d = ST_WAIT;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (hit || tmo_hit) begin
                        trig_addr_d = ptr_q;
                        forced_d    = !hit;
                        state_d     = ST_POST;
                        cnt_d       = '0;
                    end
                end
                ST_POST: begin
                    if (cnt_q == post_len - 1'b1) begin
                        state_d = ST_DONE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end else if ((state_q == ST_DONE) && rd_ack) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge ad_clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            cnt_q       <= '0;
            pre_q       <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            trig_addr_q <= '0;
            forced_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            pre_q       <= pre_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            trig_addr_q <= trig_addr_d;
            forced_q    <= forced_d;
        end
    end

    assign wr_en       = wr_en_q;
    assign wr_addr     = wr_addr_q;
    assign wr_data     = wr_data_q;
    assign trig_addr   = trig_addr_q;
    assign trig_forced = forced_q;
    assign busy        = busy_s;
    assign frame_done  = (state_q == ST_DONE);

endmodule

// File: tb/tb_wave_capture.sv
// Directed bench for wave_capture: table of trigger frames plus
// hand sequences for reset, re-arm and timeout behaviour.
module tb_wave_capture;

    logic       ad_clk = 1'b0;
    logic       rst;
    logic [7:0] ad_data;
    logic       deci_valid;
    logic [7:0] trig_level;
    logic       trig_edge;
    logic [8:0] pre_depth;
    logic       arm;
    logic       rd_ack;
    logic       wr_en;
    logic [8:0] wr_addr;
    logic [7:0] wr_data;
    logic [8:0] trig_addr;
    logic       trig_forced;
    logic       busy;
    logic       frame_done;

    wave_capture dut (
        .ad_clk     (ad_clk),
        .rst        (rst),
        .ad_data    (ad_data),
        .deci_valid (deci_valid),
        .trig_level (trig_level),
        .trig_edge  (trig_edge),
        .pre_depth  (pre_depth),
        .arm        (arm),
        .rd_ack     (rd_ack),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .trig_addr  (trig_addr),
        .trig_forced(trig_forced),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 ad_clk = ~ad_clk;

    typedef struct {
        logic       edg;
        logic [7:0] lvl;
        logic [8:0] pre;
        int         rate;
        logic [7:0] start;
        int         dir;
        logic [8:0] exp_taddr;
        logic [7:0] exp_tval;
        logic [7:0] exp_pval;
        int         exp_wr;
    } vec_t;

    int         checks = 0;
    int         failures = 0;
    int         nwr;
    int         seq_err;
    logic [8:0] exp_ptr;
    logic [7:0] mem [0:511];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Drives a ramp start+dir*k, checking every write for 1-cycle latency
    task automatic feed(input int rate, input logic [7:0] start,
                        input int dir, input int max_cyc,
                        output logic done);
        int         k = 0;
        logic       last_dv = 1'b0;
        logic       last_busy = 1'b0;
        logic [7:0] last_val = '0;
        done = 1'b0;
        for (int c = 0; c < max_cyc; c++) begin
            @(negedge ad_clk);
            if (last_dv && last_busy) begin
                if (!(wr_en === 1'b1 && wr_addr === exp_ptr &&
                      wr_data === last_val))
                    seq_err++;
                exp_ptr = exp_ptr + 1'b1;
            end else if (wr_en !== 1'b0) begin
                seq_err++;
            end
            if (wr_en === 1'b1) begin
                mem[wr_addr] = wr_data;
                nwr++;
            end
            if (frame_done === 1'b1) begin
                done = 1'b1;
                break;
            end
            last_busy  = busy;
            last_dv    = (c % rate) == 0;
            last_val   = 8'(int'(start) + dir * k);
            deci_valid = last_dv;
            ad_data    = last_val;
            if (last_dv) k++;
        end
        deci_valid = 1'b0;
    endtask

    task automatic pulse_arm();
        @(negedge ad_clk);
        arm = 1'b1;
        @(negedge ad_clk);
        arm = 1'b0;
        exp_ptr = '0;
        nwr     = 0;
        seq_err = 0;
    endtask

    task automatic pulse_ack();
        @(negedge ad_clk);
        rd_ack = 1'b1;
        @(negedge ad_clk);
        rd_ack = 1'b0;
    endtask

    vec_t       vecs [5];
    logic       done;
    logic [8:0] pidx;

    initial begin
        vecs[0] = '{1'b0, 8'd128, 9'd100, 4, 8'd0,   1,
                    9'd128, 8'd128, 8'd127, 540};
        vecs[1] = '{1'b1, 8'd128, 9'd100, 4, 8'd255, -1,
                    9'd127, 8'd128, 8'd129, 539};
        vecs[2] = '{1'b1, 8'd128, 9'd0,   3, 8'd128, -1,
                    9'd256, 8'd128, 8'd129, 768};
        vecs[3] = '{1'b0, 8'd128, 9'd511, 1, 8'd0,   1,
                    9'd128, 8'd128, 8'd127, 642};
        vecs[4] = '{1'b0, 8'd128, 9'd0,   2, 8'd0,   1,
                    9'd128, 8'd128, 8'd127, 640};

        rst = 1'b1; ad_data = '0; deci_valid = 1'b0; trig_level = '0;
        trig_edge = 1'b0; pre_depth = '0; arm = 1'b0; rd_ack = 1'b0;
        exp_ptr = '0; nwr = 0; seq_err = 0;
        repeat (3) @(negedge ad_clk);
        rst = 1'b0;
        @(negedge ad_clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", frame_done, 0);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_trig_addr", trig_addr, 0);
        chk("rst_forced", trig_forced, 0);

        for (int i = 0; i < 5; i++) begin
            trig_edge  = vecs[i].edg;
            trig_level = vecs[i].lvl;
            pre_depth  = vecs[i].pre;
            pulse_arm();
            chk($sformatf("v%0d_busy", i), busy, 1);
            feed(vecs[i].rate, vecs[i].start, vecs[i].dir, 5000, done);
            pidx = trig_addr - 1'b1;
            chk($sformatf("v%0d_done", i), done, 1);
            chk($sformatf("v%0d_taddr", i), trig_addr, vecs[i].exp_taddr);
            chk($sformatf("v%0d_tval", i), mem[trig_addr], vecs[i].exp_tval);
            chk($sformatf("v%0d_pval", i), mem[pidx], vecs[i].exp_pval);
            chk($sformatf("v%0d_writes", i), nwr, vecs[i].exp_wr);
            chk($sformatf("v%0d_forced", i), trig_forced, 0);
            chk($sformatf("v%0d_seq", i), seq_err, 0);
            if (i < 4) begin
                pulse_ack();
                chk($sformatf("v%0d_ack_done", i), frame_done, 0);
            end
        end

        // arm alone in DONE is ignored; arm with rd_ack re-arms
        pulse_arm();
        chk("done_arm_done", frame_done, 1);
        chk("done_arm_busy", busy, 0);
        trig_edge = 1'b0; trig_level = 8'd128; pre_depth = 9'd10;
        @(negedge ad_clk);
        arm = 1'b1; rd_ack = 1'b1;
        @(negedge ad_clk);
        arm = 1'b0; rd_ack = 1'b0;
        exp_ptr = '0; nwr = 0; seq_err = 0;
        chk("rearm_busy", busy, 1);
        chk("rearm_done", frame_done, 0);

        // abort with reset while in POST
        feed(1, 8'd0, 1, 200, done);
        chk("post_not_done", done, 0);
        chk("post_taddr", trig_addr, 128);
        chk("post_busy", busy, 1);
        chk("post_seq", seq_err, 0);
        chk("post_wraps", nwr, 199);
        @(negedge ad_clk);
        rst = 1'b1; deci_valid = 1'b1; ad_data = 8'd5;
        @(negedge ad_clk);
        rst = 1'b0; deci_valid = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_wr_en", wr_en, 0);
        chk("abort_done", frame_done, 0);
        chk("abort_wr_addr", wr_addr, 0);
        chk("abort_taddr", trig_addr, 0);

        // constant input never crosses the level
        trig_level = 8'd128; trig_edge = 1'b0; pre_depth = 9'd0;
        pulse_arm();
`ifdef AUTO_TRIG_EN
        feed(1, 8'd50, 0, 3000, done);
        chk("auto_done", done, 1);
        chk("auto_forced", trig_forced, 1);
        chk("auto_taddr", trig_addr, 510);
        chk("auto_writes", nwr, 1534);
        chk("auto_seq", seq_err, 0);
        @(negedge ad_clk);
        arm = 1'b1; rd_ack = 1'b1;
        @(negedge ad_clk);
        arm = 1'b0; rd_ack = 1'b0;
        chk("auto_rearm_forced", trig_forced, 0);
`else
        feed(1, 8'd50, 0, 1200, done);
        chk("noauto_done", done, 0);
        chk("noauto_busy", busy, 1);
        chk("noauto_forced", trig_forced, 0);
        chk("noauto_seq", seq_err, 0);
`endif
        @(negedge ad_clk);
        rst = 1'b1;
        @(negedge ad_clk);
        rst = 1'b0;
        chk("final_busy", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
